// File: rtl/rep_cmp_sequencer_if.sv
// Operand handshake and shared alu32 bus used by the REP compare sequencer.
// The sequencer takes the slave modport; the operand source / alu side takes master.
interface rep_cmp_sequencer_if;
  logic        opnd_valid;
  logic        opnd_ready;
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic [31:0] alu_flags;

  modport master (
    output opnd_valid, opnd_a, opnd_b, alu_out, alu_flags,
    input  opnd_ready, alu_op, alu_a, alu_b
  );

  modport slave (
    input  opnd_valid, opnd_a, opnd_b, alu_out, alu_flags,
    output opnd_ready, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/rep_cmp_sequencer.sv
// REP/REPE/REPNE CMPS/SCAS sequencer: per iteration takes an operand pair, compares
// with alu SUB, decrements the count with alu ADD, and writes EFLAGS/ECX back.
module rep_cmp_sequencer #(
  parameter int unsigned CNT_W  = 32,
  parameter logic [2:0]  OP_ADD = 3'd0,
  parameter logic [2:0]  OP_SUB = 3'd6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start,
  input  logic [1:0]                rep_mode,
  input  logic [31:0]               ecx_in,
  input  logic [31:0]               flags_in,
  input  logic                      flush,
  rep_cmp_sequencer_if.slave        bus,
  output logic                      busy,
  output logic                      flags_we,
  output logic [31:0]               flags_out,
  output logic                      ecx_we,
  output logic [31:0]               ecx_out,
  output logic                      done
);

  localparam logic [31:0] CNT_MASK = 32'((33'd1 << CNT_W) - 33'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT_OPND,
    S_CMP,
    S_DEC,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt, flg, a_q, b_q;
  logic [1:0]  mode_q;
  logic        load, term;
  logic [31:0] cnt_dec;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      cnt    <= '0;
      flg    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cnt    <= ecx_in & CNT_MASK;
        flg    <= flags_in;
        mode_q <= rep_mode;
      end
      if (bus.opnd_valid && bus.opnd_ready) begin
        a_q <= bus.opnd_a;
        b_q <= bus.opnd_b;
      end
      if (flags_we) flg <= flags_out;
      if (ecx_we)   cnt <= ecx_out;
    end
  end

  // Termination looks at ZF as written by the preceding CMP (already in flg).
  assign cnt_dec = bus.alu_out & CNT_MASK;
  assign term    = (cnt_dec == '0) ||
                   ((mode_q == 2'b01) && !flg[6]) ||
                   ((mode_q == 2'b10) &&  flg[6]);

  always_comb begin
    state_nxt      = state;
    load           = 1'b0;
    busy           = 1'b0;
    bus.opnd_ready = 1'b0;
    bus.alu_op     = '0;
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    flags_we       = 1'b0;
    flags_out      = '0;
    ecx_we         = 1'b0;
    ecx_out        = '0;
    done           = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        busy      = 1'b1;
        state_nxt = (cnt == '0) ? S_DONE : S_WAIT_OPND;
      end
      S_WAIT_OPND: begin
        busy           = 1'b1;
        bus.opnd_ready = 1'b1;
        if (bus.opnd_valid) state_nxt = S_CMP;
      end
      S_CMP: begin
        busy       = 1'b1;
        bus.alu_op = OP_SUB;
        bus.alu_a  = b_q;
        bus.alu_b  = a_q;
        flags_we   = 1'b1;
        flags_out  = {bus.alu_flags[31:11], flg[10], bus.alu_flags[9:0]};
        state_nxt  = S_DEC;
      end
      S_DEC: begin
        busy       = 1'b1;
        bus.alu_op = OP_ADD;
        bus.alu_a  = cnt;
        bus.alu_b  = '1;
        ecx_we     = 1'b1;
        ecx_out    = cnt_dec;
        state_nxt  = term ? S_DONE : S_WAIT_OPND;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Flush overrides everything: no load, handshake, strobe or done this cycle.
    if (flush) begin
      state_nxt      = S_IDLE;
      load           = 1'b0;
      bus.opnd_ready = 1'b0;
      flags_we       = 1'b0;
      ecx_we         = 1'b0;
      done           = 1'b0;
    end
  end

endmodule

// File: tb/tb_rep_cmp_sequencer.sv
// Scoreboard bench for rep_cmp_sequencer: a reference model predicts the EFLAGS/ECX
// writes and completion of each REP sequence; a monitor checks what the DUT emits.
module tb_rep_cmp_sequencer;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic        start, start16, flush;
  logic [1:0]  rep_mode;
  logic [31:0] ecx_in, flags_in;
  logic        busy, flags_we, ecx_we, done;
  logic [31:0] flags_out, ecx_out;
  logic        busy16, flags_we16, ecx_we16, done16;
  logic [31:0] flags_out16, ecx_out16;

  rep_cmp_sequencer_if bus();
  rep_cmp_sequencer_if bus16();

  rep_cmp_sequencer dut (
    .CLK(CLK), .RST(RST), .start(start), .rep_mode(rep_mode), .ecx_in(ecx_in),
    .flags_in(flags_in), .flush(flush), .bus(bus.slave), .busy(busy),
    .flags_we(flags_we), .flags_out(flags_out), .ecx_we(ecx_we), .ecx_out(ecx_out),
    .done(done)
  );

  rep_cmp_sequencer #(.CNT_W(16)) dut16 (
    .CLK(CLK), .RST(RST), .start(start16), .rep_mode(rep_mode), .ecx_in(ecx_in),
    .flags_in(flags_in), .flush(flush), .bus(bus16.slave), .busy(busy16),
    .flags_we(flags_we16), .flags_out(flags_out16), .ecx_we(ecx_we16), .ecx_out(ecx_out16),
    .done(done16)
  );

  // alu32 stand-in: op 0 ADD (a+b), op 6 SUB (b-a); bit 10 always set to expose DF handling.
  function automatic logic [63:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    logic        of;
    logic [31:0] f;
    r  = '0;
    of = 1'b0;
    if (op == 3'd0) begin
      r  = {1'b0, a} + {1'b0, b};
      of = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (op == 3'd6) begin
      r  = {1'b0, b} - {1'b0, a};
      of = (a[31] != b[31]) && (r[31] != b[31]);
    end
    f     = '0;
    f[0]  = r[32];
    f[2]  = ~^r[7:0];
    f[6]  = (r[31:0] == 32'd0);
    f[7]  = r[31];
    f[10] = 1'b1;
    f[11] = of;
    return {f, r[31:0]};
  endfunction

  always_comb {bus.alu_flags, bus.alu_out}     = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);
  always_comb {bus16.alu_flags, bus16.alu_out} = alu_model(bus16.alu_op, bus16.alu_a, bus16.alu_b);

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  localparam int EV_FLAGS = 0;
  localparam int EV_ECX   = 1;
  localparam int EV_DONE  = 2;

  typedef struct { int kind; logic [31:0] data; } ev_t;
  typedef struct { logic [31:0] a; logic [31:0] b; } pair_t;

  ev_t         exp_q[$];
  pair_t       pair_q[$];
  pair_t       fixed_q[$];
  bit          always_valid = 1'b1;
  logic [31:0] last_flags, last_ecx;

  task automatic sb(input int kind, input logic [31:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected actual_kind=%0d data=%h expected=none at %0t", kind, data, $time);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", kind, e.kind);
      check("sb_data", data, e.data);
    end
  endtask

  // Monitor: every strobe/done the DUT presents is matched against the next expectation.
  always @(negedge CLK) begin
    if (!RST) begin
      if (flags_we) begin sb(EV_FLAGS, flags_out); last_flags = flags_out; end
      if (ecx_we)   begin sb(EV_ECX, ecx_out);     last_ecx   = ecx_out;   end
      if (done)     sb(EV_DONE, 32'd0);
    end
  end

  // Operand source: pops a pair when the handshake completes, then offers the next one.
  initial begin
    bus.opnd_valid = 1'b0;
    bus.opnd_a     = '0;
    bus.opnd_b     = '0;
    forever begin
      @(posedge CLK);
      if (!RST && bus.opnd_valid && bus.opnd_ready) void'(pair_q.pop_front());
      #1;
      if (pair_q.size() > 0 && (always_valid || $urandom_range(0, 2) != 0)) begin
        bus.opnd_valid = 1'b1;
        bus.opnd_a     = pair_q[0].a;
        bus.opnd_b     = pair_q[0].b;
      end else begin
        bus.opnd_valid = 1'b0;
      end
    end
  end

  // Reference: plain architectural REP semantics on a count and a flags word.
  task automatic run_seq(input logic [1:0] m, input logic [31:0] ecx, input logic [31:0] fl, input bit av);
    logic [31:0] cnt, flg, diff, f;
    pair_t       p;
    int          iters, cyc, ready_seen;
    bit          got;
    cnt   = ecx;
    flg   = fl;
    iters = 0;
    if (cnt != 0) begin
      forever begin
        if (fixed_q.size() > 0) p = fixed_q.pop_front();
        else begin
          p.a = $urandom_range(0, 1) ? $urandom() : $urandom_range(0, 3);
          p.b = $urandom_range(0, 1) ? p.a : $urandom();
        end
        pair_q.push_back(p);
        diff  = p.a - p.b;
        f     = '0;
        f[0]  = p.a < p.b;
        f[2]  = ~^diff[7:0];
        f[6]  = diff == 0;
        f[7]  = diff[31];
        f[10] = flg[10];
        f[11] = (p.a[31] != p.b[31]) && (diff[31] != p.a[31]);
        flg   = f;
        exp_q.push_back('{EV_FLAGS, f});
        cnt = cnt - 1;
        exp_q.push_back('{EV_ECX, cnt});
        iters++;
        if (cnt == 0 || (m == 2'b01 && !flg[6]) || (m == 2'b10 && flg[6])) break;
      end
    end
    exp_q.push_back('{EV_DONE, 32'd0});
    always_valid = av;
    @(negedge CLK);
    start    = 1'b1;
    rep_mode = m;
    ecx_in   = ecx;
    flags_in = fl;
    cyc = 0; ready_seen = 0; got = 1'b0;
    repeat (400) begin
      @(negedge CLK);
      start = 1'b0;
      cyc++;
      if (bus.opnd_ready) ready_seen++;
      if (done) begin got = 1'b1; break; end
    end
    check("done_seen", 32'(got), 32'd1);
    if (av || iters == 0) check("latency", cyc, 2 + 3 * iters);
    if (iters == 0) check("no_ready_zero_cnt", ready_seen, 0);
    @(negedge CLK);
    check("done_one_cycle", 32'(done), 32'd0);
    check("sb_drained", exp_q.size(), 0);
  endtask

  // CNT_W=16 instance: count iterations and final ECX directly.
  task automatic run16(input logic [31:0] ecx, input int exp_iters, input int exp_lat);
    int  cyc, writes, readies;
    bit  got;
    logic [31:0] last;
    @(negedge CLK);
    start16 = 1'b1; rep_mode = 2'b00; ecx_in = ecx;
    cyc = 0; writes = 0; readies = 0; got = 1'b0; last = 32'hDEAD_BEEF;
    repeat (50) begin
      @(negedge CLK);
      start16 = 1'b0;
      cyc++;
      if (bus16.opnd_ready) readies++;
      if (ecx_we16) begin writes++; last = ecx_out16; end
      if (done16) begin got = 1'b1; break; end
    end
    check("w16_done", 32'(got), 32'd1);
    check("w16_latency", cyc, exp_lat);
    check("w16_ecx_writes", writes, exp_iters);
    if (exp_iters > 0) check("w16_ecx_out", last, 32'd0);
    else check("w16_no_ready", readies, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit seen;
    RST = 1'b1; start = 1'b0; start16 = 1'b0; flush = 1'b0;
    rep_mode = '0; ecx_in = '0; flags_in = '0;
    bus16.opnd_valid = 1'b1; bus16.opnd_a = 32'd3; bus16.opnd_b = 32'd3;
    repeat (3) @(negedge CLK);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_strobes", {30'd0, flags_we, ecx_we}, 32'd0);
    check("rst_ready", 32'(bus.opnd_ready), 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_outs", flags_out | ecx_out, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    run_seq(2'b00, 32'd0, 32'h0000_0202, 1'b1);

    fixed_q = '{'{32'd5, 32'd5}, '{32'd7, 32'd7}, '{32'd9, 32'd9}};
    run_seq(2'b01, 32'd3, 32'h0000_0002, 1'b1);
    check("repe3_ecx", last_ecx, 32'd0);
    check("repe3_zf", 32'(last_flags[6]), 32'd1);

    fixed_q = '{'{32'd1, 32'd1}, '{32'd2, 32'd3}};
    run_seq(2'b01, 32'd5, 32'h0000_0402, 1'b1);
    check("repe5_ecx", last_ecx, 32'd3);
    check("repe5_zf_cf_sf", {29'd0, last_flags[6], last_flags[0], last_flags[7]}, 32'b011);
    check("repe5_df", 32'(last_flags[10]), 32'd1);

    fixed_q = '{'{32'd1, 32'd2}, '{32'd4, 32'd4}};
    run_seq(2'b10, 32'd4, 32'h0000_0002, 1'b1);
    check("repne_ecx", last_ecx, 32'd2);
    check("repne_zf", 32'(last_flags[6]), 32'd1);

    run16(32'hABCD_0001, 1, 5);
    run16(32'h0001_0000, 0, 2);

    // Flush while parked in WAIT_OPND: no pairs offered, nothing expected.
    @(negedge CLK);
    start = 1'b1; rep_mode = 2'b01; ecx_in = 32'd9; flags_in = 32'h2;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      start = 1'b0;
      if (bus.opnd_ready) begin seen = 1'b1; break; end
    end
    check("flush_wait_reached", 32'(seen), 32'd1);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    check("flush_idle", 32'(busy), 32'd0);
    cyc = 0;
    repeat (6) begin
      @(negedge CLK);
      if (done || busy) cyc++;
    end
    check("flush_quiet", cyc, 0);
    run_seq(2'b00, 32'd2, 32'h0000_0002, 1'b1);

    for (int n = 0; n < 30; n++) begin
      run_seq(2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 6)),
              $urandom(), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
